layer0_input_packer: RTL and testbench
======================================

LAYER0_INPUT_PACKER -- requirements
Module: layer0_input_packer

Interface
REQ-001 SHALL have parameter FEAT_W, default 2: bits per quantized input feature.
REQ-002 SHALL have parameter N_FEAT, default 49: number of features per frame (layer-0 input vector).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port s_feat, input, FEAT_W: one quantized feature per beat.
REQ-006 SHALL have port s_valid, input, 1: upstream beat valid.
REQ-007 SHALL have port s_last, input, 1: marks the final feature of a frame.
REQ-008 SHALL have port s_ready, output, 1: packer accepts a beat.
REQ-009 SHALL have port M0, output, N_FEAT*FEAT_W: packed vector feeding the layer-0 neuron inputs.
REQ-010 SHALL have port m_valid, output, 1: M0 holds a complete frame.
REQ-011 SHALL have port m_ready, input, 1: downstream consumes M0.
REQ-012 SHALL have port err_len, output, 1: one-cycle pulse on a framing error.
REQ-013 SHALL have port frames_ok, output, 16: count of frames delivered.

Function
REQ-014 SHALL transfer an input beat only when s_valid and s_ready are both 1 in the same cycle.
REQ-015 SHALL place feature index i of a frame in bits [i*FEAT_W +: FEAT_W] of the assembly register (feature 0 at LSBs).
REQ-016 SHALL use a feature index counter of width clog2(N_FEAT), cleared at frame end, on error and on reset.
REQ-017 SHALL implement states FILL, HOLD, DISCARD.
REQ-018 In FILL, s_ready SHALL be 1; each transfer writes one feature and increments the index.
REQ-019 When the transfer at index N_FEAT-1 has s_last=1, the frame SHALL be complete: copy to the output register in the same edge if the output register is empty or is being consumed that cycle (m_valid and m_ready), otherwise go to HOLD.
REQ-020 In HOLD, s_ready SHALL be 0; on the first cycle with m_valid and m_ready both 1, the assembly register SHALL load into the output register and the state SHALL return to FILL.
REQ-021 The output register update SHALL give a zero-bubble path: a completed frame becomes m_valid=1 on the cycle after its last beat, with back-to-back frames sustaining one beat per cycle when m_ready=1.
REQ-022 m_valid SHALL stay 1 and M0 SHALL stay constant until m_valid and m_ready are both 1; after that handshake, m_valid SHALL fall unless a new frame loads in the same edge.
REQ-023 A transfer with s_last=1 at index < N_FEAT-1 SHALL discard the partial frame, pulse err_len, clear the index, and stay in FILL.
REQ-024 A transfer at index N_FEAT-1 with s_last=0 SHALL discard the frame, pulse err_len, and enter DISCARD.
REQ-025 In DISCARD, s_ready SHALL be 1, beats SHALL be dropped, and the transfer with s_last=1 SHALL return the state to FILL with index 0.
REQ-026 frames_ok SHALL increment by 1 on each m_valid and m_ready handshake, saturating at 16'hFFFF.
REQ-027 err_len SHALL be registered and SHALL be 1 for exactly one cycle per error event.
REQ-028 Latency from the last input beat to m_valid SHALL be 1 cycle when the output register is free.

Reset
REQ-029 While rst_n=0, state SHALL be FILL, index 0, and s_ready=0, m_valid=0, M0=0, err_len=0, frames_ok=0; s_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-030 Asserting rst_n mid-frame or in HOLD SHALL abandon all partial and pending data without asserting err_len.

Verification (bench uses FEAT_W=2, N_FEAT=3)
REQ-031 Send beats 2'b01, 2'b10, 2'b11 (last on the third) with m_ready=1 -> next cycle m_valid=1, M0=6'b111001, frames_ok=1 after the handshake.
REQ-032 Hold m_ready=0, send frame A=(1,1,1) and then frame B=(2,2,2) -> M0 holds 6'b010101; s_ready=0 after B completes; raise m_ready -> next M0=6'b101010 with no lost beats.
REQ-033 Send s_last on the second beat -> err_len pulses once, m_valid stays 0, and the next clean frame packs correctly from index 0.
REQ-034 Send three beats without s_last, then two junk beats, last on the second junk beat -> err_len pulses once at the third beat, junk is dropped, and the following frame is delivered.
REQ-035 Assert rst_n=0 after two beats, then release -> all outputs are zero and the next 3-beat frame yields the correct M0 with frames_ok=1.
REQ-036 Preload frames_ok to 16'hFFFE by stimulus and deliver 3 frames -> frames_ok ends at 16'hFFFF.

Source files
------------

// File: rtl/layer0_input_packer.sv
// -----------------------------------------------------------------------------
// layer0_input_packer
//
// This block collects a stream of quantized features into one packed vector for
// the layer-0 neuron inputs. Feature i of a frame is placed at bit
// [i*FEAT_W +: FEAT_W], so feature 0 sits at the LSBs. A complete frame is
// presented on M0 with m_valid, using a valid/ready handshake.
//
// Framing errors are handled as follows:
//   - If s_last arrives early, the partial frame is dropped.
//   - If a frame runs past N_FEAT beats with no s_last, the packer drops beats
//     until the next s_last.
// In both cases err_len pulses for one cycle.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   s_feat     : one quantized feature per beat
//   s_valid    : upstream beat valid
//   s_last     : final feature of a frame
//   s_ready    : packer accepts a beat this cycle
//   M0         : packed frame (N_FEAT*FEAT_W bits)
//   m_valid    : M0 holds a complete frame
//   m_ready    : downstream consumes M0
//   err_len    : one-cycle pulse per framing error
//   frames_ok  : saturating count of delivered frames
// -----------------------------------------------------------------------------
module layer0_input_packer #(
    parameter int FEAT_W = 2,
    parameter int N_FEAT = 49
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FEAT_W-1:0]          s_feat,
    input  logic                       s_valid,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [N_FEAT*FEAT_W-1:0]   M0,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       err_len,
    output logic [15:0]                frames_ok
);

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int VEC_W = N_FEAT * FEAT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic [VEC_W-1:0]   r_asm;
    logic [VEC_W-1:0]   r_out;
    logic               r_mvalid;
    logic               r_err;
    logic               w_err_next;
    logic [15:0]        r_frames_ok;
    logic               r_alive;

    logic               w_xfer;
    logic               w_consume;
    logic               w_out_free;
    logic               w_at_end;
    logic               w_asm_write;
    logic               w_load_direct;
    logic               w_load_held;
    logic [VEC_W-1:0]   w_asm_merged;

    // r_alive keeps s_ready low while the block is in reset.
    // s_ready then comes up on the first clock edge after reset is released.
    assign s_ready    = r_alive && (r_state != HOLD);
    assign w_xfer     = s_valid && s_ready;
    assign w_consume  = r_mvalid && m_ready;
    assign w_out_free = !r_mvalid || w_consume;
    assign w_at_end   = (r_idx == LAST_IDX);

    // w_asm_merged is the assembly register with the incoming feature written
    // into the current slot. On the last beat the output register loads this
    // value directly, so a finished frame needs no extra cycle.
    generate
        for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_merge
            localparam logic [IDX_W-1:0] SLOT = IDX_W'(gi);
            assign w_asm_merged[gi*FEAT_W +: FEAT_W] =
                (r_idx == SLOT) ? s_feat : r_asm[gi*FEAT_W +: FEAT_W];
        end
    endgenerate

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_err_next    = 1'b0;
        w_asm_write   = 1'b0;
        w_load_direct = 1'b0;
        w_load_held   = 1'b0;
        case (r_state)
            FILL: begin
                if (w_xfer) begin
                    if (s_last && w_at_end) begin
                        w_idx_next  = '0;
                        w_asm_write = 1'b1;
                        if (w_out_free) begin
                            w_load_direct = 1'b1;
                        end else begin
                            w_state_next = HOLD;
                        end
                    end else if (s_last) begin
                        // s_last arrived early: drop the partial frame.
                        w_idx_next = '0;
                        w_err_next = 1'b1;
                    end else if (w_at_end) begin
                        // The frame is too long: drop beats until s_last.
                        w_idx_next   = '0;
                        w_err_next   = 1'b1;
                        w_state_next = DISCARD;
                    end else begin
                        w_asm_write = 1'b1;
                        w_idx_next  = r_idx + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (w_consume) begin
                    w_load_held  = 1'b1;
                    w_state_next = FILL;
                end
            end
            DISCARD: begin
                if (w_xfer && s_last) begin
                    w_idx_next   = '0;
                    w_state_next = FILL;
                end
            end
            default: begin
                w_state_next = FILL;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_idx       <= '0;
            r_asm       <= '0;
            r_out       <= '0;
            r_mvalid    <= 1'b0;
            r_err       <= 1'b0;
            r_frames_ok <= 16'd0;
            r_alive     <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_err   <= w_err_next;
            if (w_asm_write) begin
                r_asm <= w_asm_merged;
            end
            // Loading a new frame takes priority over the consume handshake.
            // This keeps m_valid high when frames arrive back to back.
            if (w_load_direct) begin
                r_out    <= w_asm_merged;
                r_mvalid <= 1'b1;
            end else if (w_load_held) begin
                r_out    <= r_asm;
                r_mvalid <= 1'b1;
            end else if (w_consume) begin
                r_mvalid <= 1'b0;
            end
            if (w_consume && (r_frames_ok != 16'hFFFF)) begin
                r_frames_ok <= r_frames_ok + 16'd1;
            end
        end
    end

    assign M0        = r_out;
    assign m_valid   = r_mvalid;
    assign err_len   = r_err;
    assign frames_ok = r_frames_ok;

endmodule

// File: tb/tb_layer0_input_packer.sv
module tb_layer0_input_packer;

    localparam int FEAT_W = 2;
    localparam int N_FEAT = 3;

    logic                      clk;
    logic                      rst_n;
    logic [FEAT_W-1:0]         s_feat;
    logic                      s_valid;
    logic                      s_last;
    logic                      s_ready;
    logic [N_FEAT*FEAT_W-1:0]  M0;
    logic                      m_valid;
    logic                      m_ready;
    logic                      err_len;
    logic [15:0]               frames_ok;

    int n_total;
    int n_bad;

    layer0_input_packer #(
        .FEAT_W(FEAT_W),
        .N_FEAT(N_FEAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_feat   (s_feat),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .M0       (M0),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .err_len  (err_len),
        .frames_ok(frames_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Drives one beat starting on a falling edge and waits until it is accepted.
    // The task returns on the falling edge after the accepting rising edge.
    task automatic beat(input logic [FEAT_W-1:0] f, input logic last);
        int n;
        s_feat  = f;
        s_last  = last;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("beat_accept_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        s_feat  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_M0", 32'(M0), 32'd0);
        chk("rst_err", 32'(err_len), 32'd0);
        chk("rst_frames", 32'(frames_ok), 32'd0);
        rst_n = 1'b1;
        chk("rel_s_ready_low", 32'(s_ready), 32'd0);
        cyc();
        chk("rel_s_ready_high", 32'(s_ready), 32'd1);

        // Basic frame
        m_ready = 1'b1;
        beat(2'b01, 1'b0);
        beat(2'b10, 1'b0);
        beat(2'b11, 1'b1);
        chk("t1_m_valid", 32'(m_valid), 32'd1);
        chk("t1_M0", 32'(M0), 32'b111001);
        cyc();
        chk("t1_m_valid_fall", 32'(m_valid), 32'd0);
        chk("t1_frames", 32'(frames_ok), 32'd1);

        // Backpressure: frame A is held on M0 while frame B waits
        m_ready = 1'b0;
        beat(2'd1, 1'b0); beat(2'd1, 1'b0); beat(2'd1, 1'b1);
        chk("t2_A_valid", 32'(m_valid), 32'd1);
        chk("t2_A_M0", 32'(M0), 32'b010101);
        beat(2'd2, 1'b0); beat(2'd2, 1'b0); beat(2'd2, 1'b1);
        chk("t2_hold_s_ready", 32'(s_ready), 32'd0);
        chk("t2_hold_M0", 32'(M0), 32'b010101);
        cyc();
        chk("t2_hold_M0_stable", 32'(M0), 32'b010101);
        m_ready = 1'b1;
        cyc();
        chk("t2_B_M0", 32'(M0), 32'b101010);
        chk("t2_B_valid", 32'(m_valid), 32'd1);
        chk("t2_frames_a", 32'(frames_ok), 32'd2);
        chk("t2_s_ready_back", 32'(s_ready), 32'd1);
        cyc();
        chk("t2_B_consumed", 32'(m_valid), 32'd0);
        chk("t2_frames_b", 32'(frames_ok), 32'd3);

        // s_last arrives early
        beat(2'd1, 1'b0);
        beat(2'd2, 1'b1);
        chk("t3_err_pulse", 32'(err_len), 32'd1);
        chk("t3_no_valid", 32'(m_valid), 32'd0);
        cyc();
        chk("t3_err_clear", 32'(err_len), 32'd0);
        beat(2'd3, 1'b0); beat(2'd0, 1'b0); beat(2'd2, 1'b1);
        chk("t3_err_quiet", 32'(err_len), 32'd0);
        chk("t3_M0", 32'(M0), 32'b100011);
        cyc();
        chk("t3_frames", 32'(frames_ok), 32'd4);

        // Frame too long, followed by junk beats
        beat(2'd1, 1'b0); beat(2'd2, 1'b0); beat(2'd3, 1'b0);
        chk("t4_err_pulse", 32'(err_len), 32'd1);
        beat(2'd0, 1'b0);
        chk("t4_err_once", 32'(err_len), 32'd0);
        beat(2'd1, 1'b1);
        chk("t4_junk_no_valid", 32'(m_valid), 32'd0);
        chk("t4_junk_no_err", 32'(err_len), 32'd0);
        beat(2'd2, 1'b0); beat(2'd1, 1'b0); beat(2'd3, 1'b1);
        chk("t4_M0", 32'(M0), 32'b110110);
        cyc();
        chk("t4_frames", 32'(frames_ok), 32'd5);

        // Reset in the middle of a frame
        beat(2'd1, 1'b0); beat(2'd2, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_M0", 32'(M0), 32'd0);
        chk("t5_rst_frames", 32'(frames_ok), 32'd0);
        chk("t5_rst_err", 32'(err_len), 32'd0);
        chk("t5_rst_s_ready", 32'(s_ready), 32'd0);
        rst_n = 1'b1;
        cyc();
        beat(2'd3, 1'b0); beat(2'd3, 1'b0); beat(2'd1, 1'b1);
        chk("t5_M0", 32'(M0), 32'b011111);
        chk("t5_err", 32'(err_len), 32'd0);
        cyc();
        chk("t5_frames", 32'(frames_ok), 32'd1);

        // frames_ok saturates at 16'hFFFF
        force dut.r_frames_ok = 16'hFFFE;
        cyc();
        release dut.r_frames_ok;
        @(negedge clk);
        chk("t6_preload", 32'(frames_ok), 32'h0000FFFE);
        beat(2'd1, 1'b0); beat(2'd1, 1'b0); beat(2'd2, 1'b1);
        cyc();
        chk("t6_frames_1", 32'(frames_ok), 32'h0000FFFF);
        beat(2'd1, 1'b0); beat(2'd1, 1'b0); beat(2'd2, 1'b1);
        cyc();
        chk("t6_frames_2", 32'(frames_ok), 32'h0000FFFF);
        beat(2'd3, 1'b0); beat(2'd2, 1'b0); beat(2'd1, 1'b1);
        chk("t6_M0", 32'(M0), 32'b011011);
        cyc();
        chk("t6_frames_3", 32'(frames_ok), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
